morse_key_sequencer: RTL and testbench
======================================

// Module: morse_key_sequencer
// PURPOSE
//  Single-key Morse keyer front end. It times one debounced key level and classifies each press as dot or dash.
//  It detects inter-letter and inter-word gaps and issues one-cycle dot/dash/enter/space strobes to the Morse decoder.
//  It replaces the four-button entry with timing-based sequencing and waits for decoder ready after each enter.
// PARAMETERS
//  TICK_DIV     5_000_000  clk cycles per Morse time unit (>=2)
//  DASH_UNITS   2          press held >= this many units -> dash, else dot
//  LETTER_GAP   3          key-up units after last symbol -> enter
//  WORD_GAP     7          key-up units after last symbol -> space (> LETTER_GAP)
//  LONG_UNITS   10         press held this many units -> abort letter (> DASH_UNITS)
//  MAX_SYMBOLS  4          symbols per letter; the MAX_SYMBOLS-th symbol forces an immediate enter
// PORTS
//  clk          in   1  system clock
//  rst          in   1  asynchronous, active-low reset
//  enable       in   1  1 = keying active; 0 = hold in IDLE, no strobes
//  key          in   1  debounced key level, 1 = pressed
//  dec_ready    in   1  decoder ready level (1 = letter latched)
//  dot_pulse    out  1  one-cycle dot strobe
//  dash_pulse   out  1  one-cycle dash strobe
//  enter_pulse  out  1  one-cycle enter strobe
//  space_pulse  out  1  one-cycle space strobe
//  abort_pulse  out  1  one-cycle: letter discarded (long press)
//  sym_count    out  3  symbols in current letter, 0..MAX_SYMBOLS
//  busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all pulses=0; sym_count=0; busy=0; prescaler=0; unit_cnt=0; key_q=0.
//  key_q is key registered once. rise = key & ~key_q; fall = ~key & key_q.
//  Prescaler: counts 0..TICK_DIV-1. tick=1 when it wraps. It clears to 0 on every rise and fall, so units are measured from the edge.
//  unit_cnt: 5 bits, saturating at 31. It increments on tick and clears on state entry.
//  All strobes are registered: asserted the cycle after the decision cycle, for exactly 1 cycle. At most one strobe is high per cycle.
//  States:
//   IDLE:  rise -> PRESS.
//   PRESS: fall -> emit dash if unit_cnt>=DASH_UNITS, else dot. unit_cnt is sampled before any same-cycle tick. sym_count++.
//          Then, if sym_count is now MAX_SYMBOLS -> emit enter next cycle -> WAIT_ACK; else -> GAP.
//          If unit_cnt reaches LONG_UNITS while held -> abort_pulse, sym_count=0, no strobe -> HOLD.
//   HOLD:  fall -> IDLE. No strobes.
//   GAP:   rise -> PRESS (letter continues).
//          unit_cnt==LETTER_GAP -> enter_pulse -> WAIT_ACK. unit_cnt is not cleared on this exit.
//   WAIT_ACK: sym_count=0. Key edges ignored; unit_cnt keeps counting.
//          dec_ready=1 -> WORDWAIT.
//          If dec_ready is not seen within 16 cycles -> WORDWAIT anyway.
//   WORDWAIT: rise -> PRESS (new letter, no space).
//          unit_cnt==WORD_GAP -> space_pulse -> IDLE. Only one space per gap; IDLE never emits space.
//  Simultaneous events: rise and a gap threshold in the same cycle -> the rise wins; no enter/space is emitted.
//  enable=0: next cycle state=IDLE, sym_count=0; strobes and counters cleared. A letter in progress is dropped silently.
//  Reset asserted mid-letter or mid-strobe: outputs clear immediately; no partial strobe completes.
// TESTING (TICK_DIV=4, defaults otherwise; 1 unit = 4 cycles)
//  1. Hold key 4 cycles, release, stay up -> dot_pulse once.
//     Then enter_pulse 12 cycles (+/-1) after the fall.
//     Then space_pulse 28 cycles (+/-1) after the fall. busy=0 after.
//  2. Hold 12 cycles -> dash_pulse, no dot.
//     Hold exactly 8 cycles (2 units) -> dash. Hold 7 -> dot.
//  3. Dot, gap of 1 unit, dash, then idle -> dot, dash, sym_count=2, one enter_pulse.
//     Decoder stub raises dec_ready the next cycle -> WORDWAIT, then space.
//  4. Four dots with 1-unit gaps -> enter_pulse the cycle after the 4th dot strobe. No extra enter at LETTER_GAP.
//  5. Hold key 40 cycles -> abort_pulse at unit 10, sym_count=0, no dot/dash/enter.
//     After release, no strobes.
//  6. Reset low mid-PRESS and enable low mid-GAP -> all outputs 0, busy=0, sym_count=0.
//     The next press starts a fresh letter.

Source files
------------

// File: rtl/morse_key_sequencer_if.sv
// Strobe/handshake bundle between the Morse key sequencer and the Morse decoder.
interface morse_key_sequencer_if;
    // Handshake: each *_pulse is a one-cycle valid with no backpressure; the
    // decoder must take it in that cycle. After an enter_pulse, the sequencer
    // waits for the dec_ready level (letter latched) or a 16-cycle timeout
    // before it will time the following word gap.
    logic       dot_pulse;
    logic       dash_pulse;
    logic       enter_pulse;
    logic       space_pulse;
    logic       abort_pulse;
    logic [2:0] sym_count;
    logic       busy;
    logic       dec_ready;

    modport master (
        output dot_pulse, dash_pulse, enter_pulse, space_pulse, abort_pulse,
        output sym_count, busy,
        input  dec_ready
    );

    modport slave (
        input  dot_pulse, dash_pulse, enter_pulse, space_pulse, abort_pulse,
        input  sym_count, busy,
        output dec_ready
    );
endinterface

// File: rtl/morse_key_sequencer.sv
// Single-key Morse keyer front end: times key presses into dot/dash strobes and
// key-up gaps into enter/space strobes for the downstream decoder.
module morse_key_sequencer #(
    parameter int TICK_DIV    = 5_000_000,
    parameter int DASH_UNITS  = 2,
    parameter int LETTER_GAP  = 3,
    parameter int WORD_GAP    = 7,
    parameter int LONG_UNITS  = 10,
    parameter int MAX_SYMBOLS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         key,
    morse_key_sequencer_if.master        dec,
    output logic [2:0]                   state_dbg
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS    = 3'd1,
        S_HOLD     = 3'd2,
        S_GAP      = 3'd3,
        S_FORCE    = 3'd4,
        S_WAIT_ACK = 3'd5,
        S_WORDWAIT = 3'd6
    } state_t;

    state_t        state;
    logic          key_q;
    logic          rise;
    logic          fall;
    logic          tick;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_eff;
    logic [4:0]    unit_cnt;
    logic [4:0]    unit_inc;
    logic [3:0]    wait_cnt;
    logic [2:0]    sym_count;
    logic [2:0]    sym_next;
    logic          dot_r;
    logic          dash_r;
    logic          enter_r;
    logic          space_r;
    logic          abort_r;

    assign rise = key & ~key_q;
    assign fall = ~key & key_q;

    // The edge cycle itself counts as prescaler position 0, so a unit ends
    // TICK_DIV cycles after the edge that started it.
    assign presc_eff = (rise || fall) ? '0 : presc;
    assign tick      = (presc_eff == PW'(TICK_DIV - 1));
    assign unit_inc  = (tick && unit_cnt != 5'd31) ? unit_cnt + 5'd1 : unit_cnt;
    assign sym_next  = sym_count + 3'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            key_q     <= 1'b0;
            presc     <= '0;
            unit_cnt  <= 5'd0;
            wait_cnt  <= 4'd0;
            sym_count <= 3'd0;
            dot_r     <= 1'b0;
            dash_r    <= 1'b0;
            enter_r   <= 1'b0;
            space_r   <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            key_q    <= key;
            dot_r    <= 1'b0;
            dash_r   <= 1'b0;
            enter_r  <= 1'b0;
            space_r  <= 1'b0;
            abort_r  <= 1'b0;
            presc    <= tick ? '0 : presc_eff + PW'(1);
            unit_cnt <= unit_inc;

            if (!enable) begin
                state     <= S_IDLE;
                sym_count <= 3'd0;
                presc     <= '0;
                unit_cnt  <= 5'd0;
                wait_cnt  <= 4'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rise) begin
                            state    <= S_PRESS;
                            unit_cnt <= 5'd0;
                        end
                    end
                    S_PRESS: begin
                        // A release in the abort cycle goes straight to IDLE,
                        // otherwise HOLD would wait for a fall that already happened.
                        if (unit_cnt >= 5'(LONG_UNITS)) begin
                            abort_r   <= 1'b1;
                            sym_count <= 3'd0;
                            unit_cnt  <= 5'd0;
                            state     <= fall ? S_IDLE : S_HOLD;
                        end else if (fall) begin
                            if (unit_cnt >= 5'(DASH_UNITS)) dash_r <= 1'b1;
                            else                            dot_r  <= 1'b1;
                            sym_count <= sym_next;
                            unit_cnt  <= 5'd0;
                            state     <= (sym_next == 3'(MAX_SYMBOLS)) ? S_FORCE : S_GAP;
                        end
                    end
                    S_HOLD: begin
                        if (fall) begin
                            state    <= S_IDLE;
                            unit_cnt <= 5'd0;
                        end
                    end
                    S_GAP: begin
                        if (rise) begin
                            state    <= S_PRESS;
                            unit_cnt <= 5'd0;
                        end else if (unit_cnt >= 5'(LETTER_GAP)) begin
                            enter_r   <= 1'b1;
                            sym_count <= 3'd0;
                            wait_cnt  <= 4'd0;
                            state     <= S_WAIT_ACK;
                        end
                    end
                    S_FORCE: begin
                        enter_r   <= 1'b1;
                        sym_count <= 3'd0;
                        wait_cnt  <= 4'd0;
                        state     <= S_WAIT_ACK;
                    end
                    S_WAIT_ACK: begin
                        wait_cnt <= wait_cnt + 4'd1;
                        if (dec.dec_ready || wait_cnt == 4'd15) state <= S_WORDWAIT;
                    end
                    S_WORDWAIT: begin
                        // The word gap keeps counting from the last symbol's fall.
                        if (rise) begin
                            state    <= S_PRESS;
                            unit_cnt <= 5'd0;
                        end else if (unit_cnt >= 5'(WORD_GAP)) begin
                            space_r  <= 1'b1;
                            unit_cnt <= 5'd0;
                            state    <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        sym_count <= 3'd0;
                        unit_cnt  <= 5'd0;
                    end
                endcase
            end
        end
    end

    assign dec.dot_pulse   = dot_r;
    assign dec.dash_pulse  = dash_r;
    assign dec.enter_pulse = enter_r;
    assign dec.space_pulse = space_r;
    assign dec.abort_pulse = abort_r;
    assign dec.sym_count   = sym_count;
    assign dec.busy        = (state != S_IDLE);
    assign state_dbg       = state;
endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer with TICK_DIV=4 (1 unit = 4 cycles).
module tb_morse_key_sequencer;
    localparam int TICK_DIV = 4;
    localparam logic [2:0] EV_DOT   = 3'd1;
    localparam logic [2:0] EV_DASH  = 3'd2;
    localparam logic [2:0] EV_ENTER = 3'd3;
    localparam logic [2:0] EV_SPACE = 3'd4;
    localparam logic [2:0] EV_ABORT = 3'd5;
    localparam int ST_IDLE = 0;
    localparam int ST_HOLD = 2;
    localparam int ST_WORDWAIT = 6;

    typedef struct {
        int         hold;
        logic [2:0] exp_ev;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       key = 1'b0;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;

    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];
    int         obs_t[$];

    morse_key_sequencer_if dec();

    morse_key_sequencer #(.TICK_DIV(TICK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .key       (key),
        .dec       (dec),
        .state_dbg (state_dbg)
    );

    // clock / cycle stamp
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // strobe monitor: records every strobe with its cycle stamp
    always @(negedge clk) begin : mon
        int n;
        n = int'(dec.dot_pulse) + int'(dec.dash_pulse) + int'(dec.enter_pulse)
          + int'(dec.space_pulse) + int'(dec.abort_pulse);
        if (n > 0) begin
            check("one_strobe", n, 1);
            if (dec.dot_pulse)        obs_q.push_back(EV_DOT);
            else if (dec.dash_pulse)  obs_q.push_back(EV_DASH);
            else if (dec.enter_pulse) obs_q.push_back(EV_ENTER);
            else if (dec.space_pulse) obs_q.push_back(EV_SPACE);
            else                      obs_q.push_back(EV_ABORT);
            obs_t.push_back(cyc);
        end
    end

    // driver tasks: all start and end on a falling clock edge
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        key = 1'b1;
        rise_cyc = cyc + 1;
        repeat (hold) @(negedge clk);
        key = 1'b0;
        fall_cyc = cyc + 1;
    endtask

    task automatic drop_letter();
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
    endtask

    function automatic int find_t(input logic [2:0] code);
        for (int i = 0; i < obs_q.size(); i++)
            if (obs_q[i] == code) return obs_t[i];
        return -1000;
    endfunction

    // scoreboard: drain expected vs observed strobe order
    task automatic check_events(input string name);
        logic [2:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                check(name, 0, int'(e));
            end else begin
                check(name, int'(obs_q.pop_front()), int'(e));
                void'(obs_t.pop_front());
            end
        end
        check({name, "_extra_strobes"}, obs_q.size(), 0);
        obs_q.delete();
        obs_t.delete();
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, int'(dec.busy), 0);
        check({name, "_sym_count"}, int'(dec.sym_count), 0);
    endtask

    vec_t vecs[7];

    initial begin : main
        bit seen;
        vecs[0] = '{hold: 1,  exp_ev: EV_DOT};
        vecs[1] = '{hold: 4,  exp_ev: EV_DOT};
        vecs[2] = '{hold: 7,  exp_ev: EV_DOT};
        vecs[3] = '{hold: 8,  exp_ev: EV_DASH};
        vecs[4] = '{hold: 12, exp_ev: EV_DASH};
        vecs[5] = '{hold: 5,  exp_ev: EV_DOT};
        vecs[6] = '{hold: 39, exp_ev: EV_DASH};

        dec.dec_ready = 1'b0;
        wait_cycles(3);
        check("reset_dot", int'(dec.dot_pulse), 0);
        check("reset_enter", int'(dec.enter_pulse), 0);
        check("reset_abort", int'(dec.abort_pulse), 0);
        check("reset_state", int'(state_dbg), ST_IDLE);
        check_quiet("reset");
        rst = 1'b1;
        enable = 1'b1;
        wait_cycles(2);

        // press-length classification table
        for (int i = 0; i < 7; i++) begin
            press(vecs[i].hold);
            wait_cycles(2);
            check($sformatf("vec%0d_sym_count", i), int'(dec.sym_count), 1);
            drop_letter();
            wait_cycles(1);
            exp_q.push_back(vecs[i].exp_ev);
            check_events($sformatf("vec%0d_events", i));
            check_quiet($sformatf("vec%0d_after_drop", i));
        end

        // single dot, decoder always ready: enter at +12, space at +28
        dec.dec_ready = 1'b1;
        press(4);
        wait_cycles(40);
        check("t1_dot_time", find_t(EV_DOT) - fall_cyc, 0);
        check_range("t1_enter_time", find_t(EV_ENTER) - fall_cyc, 11, 13);
        check_range("t1_space_time", find_t(EV_SPACE) - fall_cyc, 27, 29);
        exp_q.push_back(EV_DOT); exp_q.push_back(EV_ENTER); exp_q.push_back(EV_SPACE);
        check_events("t1_events");
        check_quiet("t1_end");
        dec.dec_ready = 1'b0;

        // same with the decoder never ready: 16-cycle timeout path
        press(4);
        wait_cycles(40);
        check_range("t1b_space_time", find_t(EV_SPACE) - fall_cyc, 28, 30);
        exp_q.push_back(EV_DOT); exp_q.push_back(EV_ENTER); exp_q.push_back(EV_SPACE);
        check_events("t1b_events");
        check_quiet("t1b_end");

        // dot, 1-unit gap, dash; decoder acks the cycle after enter
        press(4);
        wait_cycles(4);
        press(12);
        wait_cycles(2);
        check("t3_sym_count", int'(dec.sym_count), 2);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (dec.enter_pulse) seen = 1'b1;
        end
        check("t3_enter_seen", int'(seen), 1);
        dec.dec_ready = 1'b1;
        @(negedge clk);
        check("t3_wordwait", int'(state_dbg), ST_WORDWAIT);
        dec.dec_ready = 1'b0;
        wait_cycles(40);
        exp_q.push_back(EV_DOT); exp_q.push_back(EV_DASH);
        exp_q.push_back(EV_ENTER); exp_q.push_back(EV_SPACE);
        check_events("t3_events");
        check_quiet("t3_end");

        // four dots force an immediate enter
        for (int i = 0; i < 4; i++) begin
            press(4);
            if (i < 3) wait_cycles(4);
        end
        wait_cycles(40);
        check("t4_enter_after_dot", find_t(EV_ENTER) - fall_cyc, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back(EV_DOT);
        exp_q.push_back(EV_ENTER); exp_q.push_back(EV_SPACE);
        check_events("t4_events");
        check_quiet("t4_end");

        // long press aborts the letter, release is silent
        press(4);
        wait_cycles(4);
        key = 1'b1;
        rise_cyc = cyc + 1;
        wait_cycles(42);
        check("t5_abort_time", find_t(EV_ABORT) - rise_cyc, 40);
        check("t5_sym_count", int'(dec.sym_count), 0);
        check("t5_hold_state", int'(state_dbg), ST_HOLD);
        wait_cycles(2);
        key = 1'b0;
        wait_cycles(40);
        exp_q.push_back(EV_DOT); exp_q.push_back(EV_ABORT);
        check_events("t5_events");
        check_quiet("t5_end");

        // reset in the middle of a press
        press(4);
        wait_cycles(4);
        key = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        #1;
        check("t6_rst_state", int'(state_dbg), ST_IDLE);
        check("t6_rst_dot", int'(dec.dot_pulse), 0);
        check_quiet("t6_rst");
        @(negedge clk);
        key = 1'b0;
        wait_cycles(2);
        rst = 1'b1;
        wait_cycles(2);
        exp_q.push_back(EV_DOT);
        check_events("t6_rst_events");

        // enable dropped in the middle of a gap
        press(4);
        wait_cycles(3);
        check("t6_gap_sym_count", int'(dec.sym_count), 1);
        enable = 1'b0;
        wait_cycles(1);
        check_quiet("t6_enable_low");
        enable = 1'b1;
        wait_cycles(20);
        exp_q.push_back(EV_DOT);
        check_events("t6_en_events");

        // next press starts a fresh letter
        dec.dec_ready = 1'b1;
        press(4);
        wait_cycles(2);
        check("t6_fresh_sym_count", int'(dec.sym_count), 1);
        wait_cycles(40);
        exp_q.push_back(EV_DOT); exp_q.push_back(EV_ENTER); exp_q.push_back(EV_SPACE);
        check_events("t6_fresh_events");
        check_quiet("t6_fresh_end");
        dec.dec_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
